// File: rtl/pong_pkg.sv
// rtl/pong_pkg.sv - shared scan-code constants, default key map and prefix FSM type
package pong_pkg;

  localparam logic [7:0] SC_E0 = 8'hE0;
  localparam logic [7:0] SC_F0 = 8'hF0;
  localparam logic [7:0] SC_E1 = 8'hE1;
  localparam logic [7:0] SC_AA = 8'hAA;
  localparam logic [7:0] SC_FC = 8'hFC;
  localparam logic [7:0] SC_00 = 8'h00;
  localparam logic [7:0] SC_FF = 8'hFF;

  localparam logic [7:0] DEF_KEY_UP1   = 8'h1D;
  localparam logic [7:0] DEF_KEY_DOWN1 = 8'h1B;
  localparam logic [7:0] DEF_KEY_UP2   = 8'h75;
  localparam logic [7:0] DEF_KEY_DOWN2 = 8'h72;
  localparam logic [7:0] DEF_KEY_START = 8'h29;

  // Number of bytes that follow E1 in the pause-key sequence.
  localparam logic [2:0] SKIP_LEN = 3'd7;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_EXT,
    ST_BRK,
    ST_EXT_BRK,
    ST_SKIP
  } prefix_state_e;

  // Self-test / error bytes from the keyboard that invalidate all held state.
  function automatic logic is_bat_code(input logic [7:0] b);
    return (b == SC_AA) || (b == SC_FC) || (b == SC_00) || (b == SC_FF);
  endfunction

endpackage

// File: rtl/pad_key_arbiter.sv
// rtl/pad_key_arbiter.sv - resolves simultaneous up/down holds to the most recently pressed key
module pad_key_arbiter (
  input  logic u,
  input  logic d,
  input  logic last,
  output logic up,
  output logic down
);

  always_comb begin
    up   = u & (~d | last);
    down = d & (~u | ~last);
  end

endmodule

// File: rtl/keyboard_pad_decoder.sv
// rtl/keyboard_pad_decoder.sv - PS/2 scan-code stream to held pad levels and a start pulse
module keyboard_pad_decoder
  import pong_pkg::*;
#(
  parameter logic [7:0] KEY_UP1   = DEF_KEY_UP1,
  parameter logic [7:0] KEY_DOWN1 = DEF_KEY_DOWN1,
  parameter logic [7:0] KEY_UP2   = DEF_KEY_UP2,
  parameter logic [7:0] KEY_DOWN2 = DEF_KEY_DOWN2,
  parameter logic [7:0] KEY_START = DEF_KEY_START
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] rx_data,
  input  logic       rx_done_tick,
  output logic       up1,
  output logic       down1,
  output logic       up2,
  output logic       down2,
  output logic       start_tick
);

  prefix_state_e state_q, state_d;
  logic [2:0]    skip_q, skip_d;
  logic          u1_q, u1_d, d1_q, d1_d, u2_q, u2_d, d2_q, d2_d, st_q, st_d;
  logic          last1_q, last1_d, last2_q, last2_d;
  logic          up1_q, up1_d, down1_q, down1_d, up2_q, up2_d, down2_q, down2_d;
  logic          start_q, start_d;
  logic          key_evt, key_ext, key_make;

  always_comb begin
    state_d  = state_q;
    skip_d   = skip_q;
    u1_d     = u1_q;
    d1_d     = d1_q;
    u2_d     = u2_q;
    d2_d     = d2_q;
    st_d     = st_q;
    last1_d  = last1_q;
    last2_d  = last2_q;
    start_d  = 1'b0;
    key_evt  = 1'b0;
    key_ext  = 1'b0;
    key_make = 1'b0;

    if (rx_done_tick) begin
      case (state_q)
        ST_IDLE: begin
          if (rx_data == SC_E0) begin
            state_d = ST_EXT;
          end else if (rx_data == SC_F0) begin
            state_d = ST_BRK;
          end else if (rx_data == SC_E1) begin
            state_d = ST_SKIP;
            skip_d  = SKIP_LEN;
          end else if (is_bat_code(rx_data)) begin
            u1_d    = 1'b0;
            d1_d    = 1'b0;
            u2_d    = 1'b0;
            d2_d    = 1'b0;
            st_d    = 1'b0;
            last1_d = 1'b0;
            last2_d = 1'b0;
          end else begin
            key_evt  = 1'b1;
            key_make = 1'b1;
          end
        end
        ST_EXT: begin
          if (rx_data == SC_F0) begin
            state_d = ST_EXT_BRK;
          end else if (rx_data != SC_E0) begin
            state_d  = ST_IDLE;
            key_evt  = 1'b1;
            key_ext  = 1'b1;
            key_make = 1'b1;
          end
        end
        ST_BRK, ST_EXT_BRK: begin
          // A stray E0 after F0 resynchronises onto a new extended prefix.
          if (rx_data == SC_E0) begin
            state_d = ST_EXT;
          end else if (rx_data != SC_F0) begin
            state_d = ST_IDLE;
            key_evt = 1'b1;
            key_ext = (state_q == ST_EXT_BRK);
          end
        end
        ST_SKIP: begin
          skip_d = skip_q - 3'd1;
          if (skip_q <= 3'd1) begin
            state_d = ST_IDLE;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end

    if (key_evt) begin
      if (!key_ext) begin
        if (rx_data == KEY_UP1) begin
          u1_d = key_make;
          if (key_make) last1_d = 1'b1;
        end
        if (rx_data == KEY_DOWN1) begin
          d1_d = key_make;
          if (key_make) last1_d = 1'b0;
        end
        if (rx_data == KEY_START) begin
          st_d    = key_make;
          start_d = key_make & ~st_q;
        end
      end else begin
        if (rx_data == KEY_UP2) begin
          u2_d = key_make;
          if (key_make) last2_d = 1'b1;
        end
        if (rx_data == KEY_DOWN2) begin
          d2_d = key_make;
          if (key_make) last2_d = 1'b0;
        end
      end
    end
  end

  pad_key_arbiter u_arb_p1 (
    .u    (u1_d),
    .d    (d1_d),
    .last (last1_d),
    .up   (up1_d),
    .down (down1_d)
  );

  pad_key_arbiter u_arb_p2 (
    .u    (u2_d),
    .d    (d2_d),
    .last (last2_d),
    .up   (up2_d),
    .down (down2_d)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      skip_q  <= 3'd0;
      u1_q    <= 1'b0;
      d1_q    <= 1'b0;
      u2_q    <= 1'b0;
      d2_q    <= 1'b0;
      st_q    <= 1'b0;
      last1_q <= 1'b0;
      last2_q <= 1'b0;
      up1_q   <= 1'b0;
      down1_q <= 1'b0;
      up2_q   <= 1'b0;
      down2_q <= 1'b0;
      start_q <= 1'b0;
    end else begin
      state_q <= state_d;
      skip_q  <= skip_d;
      u1_q    <= u1_d;
      d1_q    <= d1_d;
      u2_q    <= u2_d;
      d2_q    <= d2_d;
      st_q    <= st_d;
      last1_q <= last1_d;
      last2_q <= last2_d;
      up1_q   <= up1_d;
      down1_q <= down1_d;
      up2_q   <= up2_d;
      down2_q <= down2_d;
      start_q <= start_d;
    end
  end

  assign up1        = up1_q;
  assign down1      = down1_q;
  assign up2        = up2_q;
  assign down2      = down2_q;
  assign start_tick = start_q;

endmodule

// File: tb/tb_keyboard_pad_decoder.sv
// tb/tb_keyboard_pad_decoder.sv - table-driven scoreboard bench for keyboard_pad_decoder
module tb_keyboard_pad_decoder;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] rx_data;
  logic       rx_done_tick;
  logic       up1, down1, up2, down2, start_tick;

  keyboard_pad_decoder dut (
    .clk          (clk),
    .rst          (rst),
    .rx_data      (rx_data),
    .rx_done_tick (rx_done_tick),
    .up1          (up1),
    .down1        (down1),
    .up2          (up2),
    .down2        (down2),
    .start_tick   (start_tick)
  );

  always #5 clk = ~clk;

  // exp packs {up1, down1, up2, down2, start_tick} for the cycle after the input.
  typedef struct {
    logic [7:0] data;
    logic       tick;
    logic [4:0] exp;
  } vec_t;

  vec_t       vecs[$];
  logic [4:0] exp_q[$];
  int         n_checks = 0;
  int         n_fail   = 0;
  int         step_id  = 0;

  task automatic add(input logic [7:0] d, input logic t, input logic [4:0] e);
    vec_t v;
    v.data = d;
    v.tick = t;
    v.exp  = e;
    vecs.push_back(v);
  endtask

  task automatic compare_outputs(input string name);
    logic [4:0] got;
    logic [4:0] want;
    got  = {up1, down1, up2, down2, start_tick};
    want = exp_q.pop_front();
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got {up1,down1,up2,down2,start}=%b expected %b", name, got, want);
    end
  endtask

  task automatic step(input logic [7:0] d, input logic t, input logic [4:0] e, input string name);
    @(negedge clk);
    rx_data      = d;
    rx_done_tick = t;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    compare_outputs(name);
    step_id++;
  endtask

  task automatic byte_in(input logic [7:0] d, input logic [4:0] e, input string name);
    step(d, 1'b1, e, name);
  endtask

  initial begin
    rst          = 1'b1;
    rx_data      = 8'h00;
    rx_done_tick = 1'b0;

    // Plain make/break of W.
    add(8'h1D, 1, 5'b10000);
    add(8'hF0, 1, 5'b10000);
    add(8'h1D, 1, 5'b00000);
    // Extended arrow-up, plain 75 ignored, extended break.
    add(8'hE0, 1, 5'b00000);
    add(8'h75, 1, 5'b00100);
    add(8'h75, 1, 5'b00100);
    add(8'hE0, 1, 5'b00100);
    add(8'hF0, 1, 5'b00100);
    add(8'h75, 1, 5'b00000);
    // Extended 1D must not touch up1.
    add(8'hE0, 1, 5'b00000);
    add(8'h1D, 1, 5'b00000);
    // Both held: newest wins, release hands back, typematic up retakes control.
    add(8'h1D, 1, 5'b10000);
    add(8'h1B, 1, 5'b01000);
    add(8'h1D, 1, 5'b10000);
    add(8'h1B, 1, 5'b01000);
    add(8'hF0, 1, 5'b01000);
    add(8'h1B, 1, 5'b10000);
    add(8'hF0, 1, 5'b10000);
    add(8'h1D, 1, 5'b00000);
    // Start: one pulse for held repeats, fresh press after break pulses again.
    add(8'h29, 1, 5'b00001);
    add(8'h00, 0, 5'b00000);
    add(8'h29, 1, 5'b00000);
    add(8'h29, 1, 5'b00000);
    add(8'hF0, 1, 5'b00000);
    add(8'h29, 1, 5'b00000);
    add(8'h29, 1, 5'b00001);
    add(8'hF0, 1, 5'b00000);
    add(8'h29, 1, 5'b00000);
    // Pause sequence with S held.
    add(8'h1B, 1, 5'b01000);
    add(8'hE1, 1, 5'b01000);
    add(8'h14, 1, 5'b01000);
    add(8'h77, 1, 5'b01000);
    add(8'hE1, 1, 5'b01000);
    add(8'hF0, 1, 5'b01000);
    add(8'h14, 1, 5'b01000);
    add(8'hF0, 1, 5'b01000);
    add(8'h77, 1, 5'b01000);
    add(8'hF0, 1, 5'b01000);
    add(8'h1B, 1, 5'b00000);
    // F0 then E0 resyncs onto an extended make; arrow-down arbitration.
    add(8'hF0, 1, 5'b00000);
    add(8'hE0, 1, 5'b00000);
    add(8'h75, 1, 5'b00100);
    add(8'hE0, 1, 5'b00100);
    add(8'h72, 1, 5'b00010);
    add(8'hE0, 1, 5'b00010);
    add(8'hF0, 1, 5'b00010);
    add(8'h72, 1, 5'b00100);
    // BAT FF clears everything held.
    add(8'h1D, 1, 5'b10100);
    add(8'h00, 0, 5'b10100);
    add(8'hFF, 1, 5'b00000);

    repeat (2) @(negedge clk);
    #1;
    exp_q.push_back(5'b00000);
    compare_outputs("reset_state");
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      step(vecs[i].data, vecs[i].tick, vecs[i].exp, $sformatf("vec%0d_%02h", i, vecs[i].data));
    end

    // Reset in the middle of an E0 prefix.
    byte_in(8'h1D, 5'b10000, "rst_pre_1D");
    byte_in(8'hE0, 5'b10000, "rst_pre_E0");
    @(negedge clk);
    rst          = 1'b1;
    rx_done_tick = 1'b0;
    exp_q.push_back(5'b00000);
    @(posedge clk);
    #1;
    compare_outputs("rst_mid_seq");
    @(negedge clk);
    rst = 1'b0;
    byte_in(8'h75, 5'b00000, "rst_post_75_plain");
    byte_in(8'h1D, 5'b10000, "rst_post_1D");
    byte_in(8'hAA, 5'b00000, "bat_AA_clear");
    step(8'h00, 1'b0, 5'b00000, "final_idle");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
